// File: rtl/mem_responder.sv
// Byte-addressed memory responder: latches a request, waits WAIT cycles,
// commits a big-endian word/halfword/byte access and pulses Ready (and Error
// on a fault) for one cycle.
module mem_responder #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned WAIT   = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_address,
    input  logic [31:0] i_data_in,
    output logic [31:0] o_data_out,
    output logic        o_ready,
    output logic        o_error,
    output logic        o_busy
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_wr;
    logic [1:0]         r_size;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_data_out;
    logic               r_ready;
    logic               r_error;
    logic               r_busy;
    logic [7:0]         r_mem [DEPTH];

    logic [ADDR_W-1:0]  w_idx0;
    logic [ADDR_W-1:0]  w_idx1;
    logic [ADDR_W-1:0]  w_idx2;
    logic [ADDR_W-1:0]  w_idx3;
    logic               w_out_of_range;
    logic               w_fault;
    logic               w_commit;
    logic [31:0]        w_rdata;

    // Byte lanes of the latched access; only meaningful when aligned
    assign w_idx0 = r_addr[ADDR_W-1:0];
    assign w_idx1 = {w_idx0[ADDR_W-1:1], 1'b1};
    assign w_idx2 = {w_idx0[ADDR_W-1:2], 2'b10};
    assign w_idx3 = {w_idx0[ADDR_W-1:2], 2'b11};

    assign w_out_of_range = (r_addr >> ADDR_W) != 32'd0;
    assign w_fault  = (r_size == 2'b11)
                    || ((r_size == 2'b00) && (r_addr[1:0] != 2'b00))
                    || ((r_size == 2'b01) && r_addr[0])
                    || w_out_of_range;
    assign w_commit = (r_state == ST_WAIT) && (r_cnt == CNT_W'(0));

    // Big-endian read data for the latched access
    always_comb begin
        w_rdata = 32'd0;
        case (r_size)
            2'b00:   w_rdata = {r_mem[w_idx0], r_mem[w_idx1], r_mem[w_idx2], r_mem[w_idx3]};
            2'b01:   w_rdata = {16'd0, r_mem[w_idx0], r_mem[w_idx1]};
            2'b10:   w_rdata = {24'd0, r_mem[w_idx0]};
            default: w_rdata = 32'd0;
        endcase
    end

    // Memory array: written only at the commit edge of a good write, never reset
    always_ff @(posedge i_clk) begin
        if (w_commit && r_wr && !w_fault) begin
            case (r_size)
                2'b00: begin
                    r_mem[w_idx0] <= r_wdata[31:24];
                    r_mem[w_idx1] <= r_wdata[23:16];
                    r_mem[w_idx2] <= r_wdata[15:8];
                    r_mem[w_idx3] <= r_wdata[7:0];
                end
                2'b01: begin
                    r_mem[w_idx0] <= r_wdata[15:8];
                    r_mem[w_idx1] <= r_wdata[7:0];
                end
                2'b10:   r_mem[w_idx0] <= r_wdata[7:0];
                default: ;
            endcase
        end
    end

    // Control FSM with request latch and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= CNT_W'(0);
            r_wr       <= 1'b0;
            r_size     <= 2'b00;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_data_out <= 32'd0;
            r_ready    <= 1'b0;
            r_error    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_req) begin
                        r_wr    <= i_wr;
                        r_size  <= i_size;
                        r_addr  <= i_address;
                        r_wdata <= i_data_in;
                        r_cnt   <= CNT_W'(WAIT);
                        r_busy  <= 1'b1;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt != CNT_W'(0)) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_ready <= 1'b1;
                        r_error <= w_fault;
                        if (w_fault) begin
                            r_data_out <= 32'd0;
                        end else if (!r_wr) begin
                            r_data_out <= w_rdata;
                        end
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_data_out = r_data_out;
    assign o_ready    = r_ready;
    assign o_error    = r_error;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a byte-array model of the memory predicts every
// access outcome; a second instance with WAIT=0 exercises continuous requests.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr, din, dout;
    logic        ready, err, busy;

    logic        req0, wr0;
    logic [1:0]  size0;
    logic [31:0] addr0, din0, dout0;
    logic        ready0, err0, busy0;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mdl [256];
    logic [31:0] exp_dout;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(8), .WAIT(2)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_wr(wr), .i_size(size),
        .i_address(addr), .i_data_in(din), .o_data_out(dout),
        .o_ready(ready), .o_error(err), .o_busy(busy)
    );

    mem_responder #(.ADDR_W(8), .WAIT(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req0), .i_wr(wr0), .i_size(size0),
        .i_address(addr0), .i_data_in(din0), .o_data_out(dout0),
        .o_ready(ready0), .o_error(err0), .o_busy(busy0)
    );

    function automatic logic mdl_fault(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b11) || (sz == 2'b00 && a[1:0] != 2'b00) ||
               (sz == 2'b01 && a[0]) || (a[31:8] != 24'h0);
    endfunction

    function automatic logic [31:0] mdl_read(input logic [1:0] sz, input logic [31:0] a);
        int i;
        i = int'(a[7:0]);
        case (sz)
            2'b00:   return {mdl[i], mdl[i+1], mdl[i+2], mdl[i+3]};
            2'b01:   return {16'h0, mdl[i], mdl[i+1]};
            default: return {24'h0, mdl[i]};
        endcase
    endfunction

    task automatic mdl_write(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        int i;
        i = int'(a[7:0]);
        case (sz)
            2'b00: begin
                mdl[i] = d[31:24]; mdl[i+1] = d[23:16]; mdl[i+2] = d[15:8]; mdl[i+3] = d[7:0];
            end
            2'b01: begin
                mdl[i] = d[15:8]; mdl[i+1] = d[7:0];
            end
            default: mdl[i] = d[7:0];
        endcase
    endtask

    // One access on the WAIT=2 instance; inputs are scrambled while busy
    task automatic access(input logic w, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] d, input string name, output logic [31:0] got);
        int   n;
        logic seen;
        logic exp_e;
        exp_e = mdl_fault(sz, a);
        if (exp_e)   exp_dout = 32'h0;
        else if (!w) exp_dout = mdl_read(sz, a);
        else         mdl_write(sz, a, d);

        req = 1'b1; wr = w; size = sz; addr = a; din = d;
        @(posedge clk); #1;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 20) begin
            req = 1'($urandom); wr = 1'($urandom); size = 2'($urandom);
            addr = $urandom; din = $urandom;
            @(posedge clk); #1;
            n++;
            if (ready === 1'b1) begin
                seen = 1'b1;
            end else begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_wait got %b exp 1", name, busy);
                end
            end
        end
        checks++;
        if (!seen || n != 3) begin
            errors++;
            $display("FAIL %s latency got %0d edges (seen=%b) exp 3", name, n, seen);
        end
        checks++;
        if (err !== exp_e) begin
            errors++;
            $display("FAIL %s error got %b exp %b", name, err, exp_e);
        end
        checks++;
        if (dout !== exp_dout) begin
            errors++;
            $display("FAIL %s data got %h exp %h", name, dout, exp_dout);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_resp got %b exp 1", name, busy);
        end
        got = dout;
        req = 1'($urandom);
        @(posedge clk); #1;
        req = 1'b0;
        checks++;
        if (ready !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || dout !== exp_dout) begin
            errors++;
            $display("FAIL %s idle got rdy=%b busy=%b err=%b data=%h exp 0 0 0 %h",
                     name, ready, busy, err, dout, exp_dout);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (ready !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || dout !== 32'h0) begin
            errors++;
            $display("FAIL %s got rdy=%b err=%b busy=%b data=%h exp all 0",
                     name, ready, err, busy, dout);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 1'b0; wr = 1'b0; size = 2'b00; addr = 32'h0; din = 32'h0;
        req0 = 1'b0; wr0 = 1'b0; size0 = 2'b00; addr0 = 32'h0; din0 = 32'h0;
        #1;
        check_all_zero("reset");
        checks++;
        if (ready0 !== 1'b0 || err0 !== 1'b0 || busy0 !== 1'b0 || dout0 !== 32'h0) begin
            errors++;
            $display("FAIL reset0 got rdy=%b err=%b busy=%b data=%h exp all 0",
                     ready0, err0, busy0, dout0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_dout = 32'h0;
    endtask

    task automatic test_preload();
        logic [31:0] got;
        for (int w = 0; w < 64; w++) begin
            access(1'b1, 2'b00, 32'(w * 4), $urandom, "preload", got);
        end
    endtask

    task automatic test_directed();
        logic [31:0] got;
        access(1'b1, 2'b00, 32'h10, 32'hDEADBEEF, "wr_word", got);
        access(1'b0, 2'b00, 32'h10, 32'h0, "rd_word", got);
        checks++;
        if (got !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rd_word_const got %h exp deadbeef", got);
        end
        access(1'b0, 2'b10, 32'h11, 32'h0, "rd_byte", got);
        checks++;
        if (got !== 32'h000000AD) begin
            errors++;
            $display("FAIL rd_byte_const got %h exp 000000ad", got);
        end
        access(1'b0, 2'b01, 32'h12, 32'h0, "rd_half", got);
        checks++;
        if (got !== 32'h0000BEEF) begin
            errors++;
            $display("FAIL rd_half_const got %h exp 0000beef", got);
        end
        access(1'b1, 2'b10, 32'h13, 32'hFFFFFF5A, "wr_byte", got);
        access(1'b0, 2'b00, 32'h10, 32'h0, "rd_after_byte", got);
        checks++;
        if (got !== 32'hDEADBE5A) begin
            errors++;
            $display("FAIL rd_after_byte_const got %h exp deadbe5a", got);
        end
        access(1'b0, 2'b00, 32'h12,  32'h0, "fault_word_misalign", got);
        access(1'b0, 2'b01, 32'h13,  32'h0, "fault_half_misalign", got);
        access(1'b0, 2'b11, 32'h00,  32'h0, "fault_size11", got);
        access(1'b1, 2'b11, 32'h10,  32'h0, "fault_wr_size11", got);
        access(1'b0, 2'b00, 32'h100, 32'h0, "fault_range", got);
        access(1'b1, 2'b00, 32'h110, 32'h0, "fault_wr_range", got);
        access(1'b0, 2'b00, 32'h10,  32'h0, "rd_after_faults", got);
        checks++;
        if (got !== 32'hDEADBE5A) begin
            errors++;
            $display("FAIL rd_after_faults_const got %h exp deadbe5a", got);
        end
    endtask

    task automatic test_random();
        logic [31:0] got;
        logic [31:0] a;
        logic [1:0]  sz;
        logic        w;
        for (int k = 0; k < 60; k++) begin
            w  = 1'($urandom);
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(8, 31));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b00) a = a & ~32'h3;
                if (sz == 2'b01) a = a & ~32'h1;
            end
            access(w, sz, a, $urandom, "random", got);
        end
    endtask

    // WAIT=0 instance: continuous Req gives IDLE, WAIT, RESP repeating
    task automatic test_wait0();
        logic [31:0] exp;
        req0 = 1'b1; wr0 = 1'b1; size0 = 2'b00; addr0 = 32'h40; din0 = 32'hCAFEF00D;
        @(posedge clk); #1;
        req0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        req0 = 1'b1; addr0 = 32'h44; din0 = 32'h0A5A5A5A;
        @(posedge clk); #1;
        req0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h40;
        for (int k = 0; k < 6; k++) begin
            exp = (k % 2 == 1) ? 32'h0A5A5A5A : 32'hCAFEF00D;
            addr0 = (k % 2 == 1) ? 32'h44 : 32'h40;
            @(posedge clk); #1;
            addr0 = (k % 2 == 1) ? 32'h40 : 32'h44;
            wr0 = 1'($urandom); din0 = $urandom;
            checks++;
            if (busy0 !== 1'b1 || ready0 !== 1'b0) begin
                errors++;
                $display("FAIL w0_wait k=%0d got busy=%b rdy=%b exp 1 0", k, busy0, ready0);
            end
            wr0 = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (busy0 !== 1'b1 || ready0 !== 1'b1 || err0 !== 1'b0 || dout0 !== exp) begin
                errors++;
                $display("FAIL w0_resp k=%0d got busy=%b rdy=%b err=%b data=%h exp 1 1 0 %h",
                         k, busy0, ready0, err0, dout0, exp);
            end
            @(posedge clk); #1;
            checks++;
            if (busy0 !== 1'b0 || ready0 !== 1'b0) begin
                errors++;
                $display("FAIL w0_idle k=%0d got busy=%b rdy=%b exp 0 0", k, busy0, ready0);
            end
        end
        req0 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] got;
        access(1'b1, 2'b00, 32'h20, 32'hA1B2C3D4, "rw_prior", got);
        access(1'b0, 2'b10, 32'h21, 32'h0, "rw_nonzero_dout", got);
        req = 1'b1; wr = 1'b1; size = 2'b00; addr = 32'h20; din = 32'h12345678;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_wait_assert");
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst_wait_hold");
        rst_n = 1'b1;
        exp_dout = 32'h0;
        access(1'b0, 2'b00, 32'h20, 32'h0, "rst_wait_read", got);
        checks++;
        if (got !== 32'hA1B2C3D4) begin
            errors++;
            $display("FAIL rst_wait_const got %h exp a1b2c3d4", got);
        end
    endtask

    task automatic test_reset_in_resp();
        logic [31:0] got;
        int n;
        req = 1'b1; wr = 1'b1; size = 2'b00; addr = 32'h20; din = 32'h12345678;
        @(posedge clk); #1;
        req = 1'b0;
        n = 0;
        while (ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_resp_ready got %b exp 1", ready);
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_resp_assert");
        @(posedge clk); #1;
        rst_n = 1'b1;
        mdl_write(2'b00, 32'h20, 32'h12345678);
        exp_dout = 32'h0;
        access(1'b0, 2'b00, 32'h20, 32'h0, "rst_resp_read", got);
        checks++;
        if (got !== 32'h12345678) begin
            errors++;
            $display("FAIL rst_resp_const got %h exp 12345678", got);
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_directed();
        test_random();
        test_wait0();
        test_reset_in_wait();
        test_reset_in_resp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
